// File: rtl/program_sequencer_pkg.sv
// ============================================================================
// program_sequencer_pkg : shared state encoding and default sizing constants
// Rev 1.0
// ============================================================================
`default_nettype none

package program_sequencer_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      RUN    = 3'd2,
      RESULT = 3'd3,
      DONE   = 3'd4
   } seq_state_t;

   localparam int                    SEQ_NUM_PROGS = 3;
   localparam int                    SEQ_PIDX_W    = 2;
   localparam int                    SEQ_CYC_W     = 16;
   localparam int                    SEQ_START_LEN = 2;
   localparam logic [SEQ_CYC_W-1:0]  SEQ_TIMEOUT   = 16'hFFF0;

endpackage

`default_nettype wire

// File: rtl/program_sequencer_cycle_timer.sv
// ============================================================================
// cycle_timer : saturating cycle counter; hit_o flags the TIMEOUT-th enabled cycle
// Rev 1.0
// ============================================================================
`default_nettype none

module cycle_timer
   import program_sequencer_pkg::*;
#(
   parameter int               CYC_W   = SEQ_CYC_W,
   parameter logic [CYC_W-1:0] TIMEOUT = SEQ_TIMEOUT
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             enable_i,
   output logic [CYC_W-1:0] count_o,
   output logic             hit_o
);

   localparam logic [CYC_W-1:0] LAST = TIMEOUT - CYC_W'(1);

   logic [CYC_W-1:0] count_q;
   logic [CYC_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i && (count_q != TIMEOUT)) begin
         count_d = count_q + CYC_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // The cycle currently being counted is the TIMEOUT-th one
   assign hit_o   = enable_i && (count_q == LAST);
   assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/program_sequencer.sv
// ============================================================================
// program_sequencer : runs programs 0..NUM_PROGS-1 on the core, timing each run
// Rev 1.0
// ============================================================================
`default_nettype none

module program_sequencer
   import program_sequencer_pkg::*;
#(
   parameter int               NUM_PROGS = SEQ_NUM_PROGS,
   parameter int               PIDX_W    = SEQ_PIDX_W,
   parameter int               CYC_W     = SEQ_CYC_W,
   parameter int               START_LEN = SEQ_START_LEN,
   parameter logic [CYC_W-1:0] TIMEOUT   = SEQ_TIMEOUT
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              Go,
   input  logic              Abort,
   input  logic              DutAck,
   output logic              DutStart,
   output logic [PIDX_W-1:0] ProgIdx,
   output logic              Busy,
   output logic              ResultValid,
   output logic [PIDX_W-1:0] ResultIdx,
   output logic [CYC_W-1:0]  CycleCount,
   output logic              TimedOut,
   output logic              Done
);

   localparam logic [PIDX_W-1:0] LAST_IDX = PIDX_W'(NUM_PROGS - 1);

   seq_state_t        state_q, state_d;
   logic [PIDX_W-1:0] idx_q, idx_d;
   logic [PIDX_W-1:0] ridx_q, ridx_d;
   logic [CYC_W-1:0]  count_q, count_d;
   logic              timed_q, timed_d;

   logic              start_hit;
   logic [CYC_W-1:0]  start_cnt_unused;
   logic              run_hit;
   logic [CYC_W-1:0]  run_cnt;
   logic [CYC_W-1:0]  run_elapsed;

   cycle_timer #(
      .CYC_W   (CYC_W),
      .TIMEOUT (CYC_W'(START_LEN))
   ) u_start_timer (
      .clk_i    (Clk),
      .rst_ni   (Reset_n),
      .clear_i  (state_q != START),
      .enable_i (state_q == START),
      .count_o  (start_cnt_unused),
      .hit_o    (start_hit)
   );

   cycle_timer #(
      .CYC_W   (CYC_W),
      .TIMEOUT (TIMEOUT)
   ) u_run_timer (
      .clk_i    (Clk),
      .rst_ni   (Reset_n),
      .clear_i  (state_q != RUN),
      .enable_i (state_q == RUN),
      .count_o  (run_cnt),
      .hit_o    (run_hit)
   );

   // Reported count includes the cycle in which Ack (or the timeout) is seen
   assign run_elapsed = run_cnt + CYC_W'(1);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      ridx_d  = ridx_q;
      count_d = count_q;
      timed_d = timed_q;

      if (Abort && (state_q != IDLE)) begin
         state_d = IDLE;
         idx_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (Go && !Abort) begin
                  state_d = START;
                  idx_d   = '0;
               end
            end
            START: begin
               if (start_hit) begin
                  state_d = RUN;
               end
            end
            RUN: begin
               if (DutAck || run_hit) begin
                  state_d = RESULT;
                  ridx_d  = idx_q;
                  count_d = run_elapsed;
                  timed_d = !DutAck;
               end
            end
            RESULT: begin
               if (idx_q == LAST_IDX) begin
                  state_d = DONE;
               end else begin
                  state_d = START;
                  idx_d   = idx_q + PIDX_W'(1);
               end
            end
            DONE: begin
               state_d = IDLE;
               idx_d   = '0;
            end
            default: begin
               state_d = IDLE;
               idx_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         ridx_q  <= '0;
         count_q <= '0;
         timed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         ridx_q  <= ridx_d;
         count_q <= count_d;
         timed_q <= timed_d;
      end
   end

   assign DutStart    = (state_q == START);
   assign Busy        = (state_q != IDLE);
   assign ResultValid = (state_q == RESULT);
   assign Done        = (state_q == DONE);
   assign ProgIdx     = idx_q;
   assign ResultIdx   = ridx_q;
   assign CycleCount  = count_q;
   assign TimedOut    = timed_q;

endmodule

`default_nettype wire

// File: tb/tb_program_sequencer.sv
// ============================================================================
// tb_program_sequencer : directed self-checking bench for program_sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_program_sequencer;

   logic        Clk;
   logic        Reset_n;
   logic        Go;
   logic        Abort;
   logic        DutAck;
   logic        DutStart;
   logic [1:0]  ProgIdx;
   logic        Busy;
   logic        ResultValid;
   logic [1:0]  ResultIdx;
   logic [15:0] CycleCount;
   logic        TimedOut;
   logic        Done;

   int n_cmp = 0;
   int n_err = 0;
   int rv_cnt = 0;
   int done_cnt = 0;

   program_sequencer #(
      .NUM_PROGS (3),
      .PIDX_W    (2),
      .CYC_W     (16),
      .START_LEN (2),
      .TIMEOUT   (16'd50)
   ) dut (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .Go          (Go),
      .Abort       (Abort),
      .DutAck      (DutAck),
      .DutStart    (DutStart),
      .ProgIdx     (ProgIdx),
      .Busy        (Busy),
      .ResultValid (ResultValid),
      .ResultIdx   (ResultIdx),
      .CycleCount  (CycleCount),
      .TimedOut    (TimedOut),
      .Done        (Done)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   always @(negedge Clk) begin
      if (ResultValid === 1'b1) rv_cnt++;
      if (Done === 1'b1) done_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic pulse_go();
      Go = 1'b1;
      @(negedge Clk);
      Go = 1'b0;
   endtask

   // Core model for one program: ack on RUN cycle ack_at (0 = never), optional abort
   task automatic do_prog(input int idx, input int ack_at, input int abort_at);
      int n;
      int hi;
      bit found;
      n = 0;
      while (DutStart !== 1'b1 && n < 20) begin
         @(negedge Clk);
         n++;
      end
      chk("start_seen", DutStart, 1);
      chk("prog_idx", ProgIdx, idx);
      chk("busy_start", Busy, 1);
      hi = 0;
      while (DutStart === 1'b1 && hi < 20) begin
         @(negedge Clk);
         hi++;
      end
      chk("start_len", hi, 2);
      found = 1'b0;
      for (int c = 1; c <= 60 && !found; c++) begin
         if (c == abort_at) begin
            Abort = 1'b1;
            @(negedge Clk);
            Abort = 1'b0;
            chk("abort_busy", Busy, 0);
            chk("abort_start", DutStart, 0);
            chk("abort_rv", ResultValid, 0);
            return;
         end
         if (c == ack_at) DutAck = 1'b1;
         @(negedge Clk);
         DutAck = 1'b0;
         if (ResultValid === 1'b1) found = 1'b1;
      end
      chk("result_seen", found, 1);
      chk("result_idx", ResultIdx, idx);
      chk("cycle_count", CycleCount, (ack_at == 0) ? 50 : ack_at);
      chk("timed_out", TimedOut, (ack_at == 0) ? 1 : 0);
   endtask

   task automatic finish_run(input int last_count);
      @(negedge Clk);
      chk("done_pulse", Done, 1);
      chk("done_rv", ResultValid, 0);
      @(negedge Clk);
      chk("done_low", Done, 0);
      chk("idle_busy", Busy, 0);
      chk("idle_idx", ProgIdx, 0);
      chk("count_held", CycleCount, last_count);
   endtask

   int rv_snap;
   int done_snap;

   initial begin
      Reset_n = 1'b0;
      Go      = 1'b0;
      Abort   = 1'b0;
      DutAck  = 1'b0;

      // 1: reset holds everything quiet even with Go; then Go -> 2-cycle DutStart
      repeat (2) @(negedge Clk);
      Go = 1'b1;
      @(negedge Clk);
      chk("rst_start", DutStart, 0);
      chk("rst_busy", Busy, 0);
      chk("rst_rv", ResultValid, 0);
      chk("rst_done", Done, 0);
      chk("rst_idx", ProgIdx, 0);
      chk("rst_ridx", ResultIdx, 0);
      chk("rst_count", CycleCount, 0);
      chk("rst_to", TimedOut, 0);
      Go = 1'b0;
      Reset_n = 1'b1;
      @(negedge Clk);
      pulse_go();
      chk("t1_start_c1", DutStart, 1);
      chk("t1_busy", Busy, 1);
      @(negedge Clk);
      chk("t1_start_c2", DutStart, 1);
      @(negedge Clk);
      chk("t1_start_off", DutStart, 0);
      chk("t1_busy_run", Busy, 1);
      Abort = 1'b1;
      @(negedge Clk);
      Abort = 1'b0;
      chk("t1_abort_idle", Busy, 0);

      // 2: three programs acked after 10, 25, 7 RUN cycles
      @(negedge Clk);
      pulse_go();
      do_prog(0, 10, 0);
      do_prog(1, 25, 0);
      do_prog(2, 7, 0);
      finish_run(7);

      // 3: program 1 hangs and times out; program 2 still runs
      pulse_go();
      do_prog(0, 5, 0);
      do_prog(1, 0, 0);
      do_prog(2, 3, 0);
      finish_run(3);

      // 4: Ack exactly at the timeout cycle wins; Ack on first RUN cycle counts 1
      pulse_go();
      do_prog(0, 50, 0);
      do_prog(1, 1, 0);
      do_prog(2, 2, 0);
      finish_run(2);

      // 5: abort during RUN of program 1, then a clean restart from 0
      rv_snap   = rv_cnt;
      done_snap = done_cnt;
      pulse_go();
      do_prog(0, 4, 0);
      do_prog(1, 0, 12);
      repeat (3) @(negedge Clk);
      chk("t5_rv_count", rv_cnt - rv_snap, 1);
      chk("t5_done_count", done_cnt - done_snap, 0);
      chk("t5_idle_idx", ProgIdx, 0);
      pulse_go();
      do_prog(0, 6, 0);
      do_prog(1, 8, 0);
      do_prog(2, 9, 0);
      finish_run(9);

      // 6: Go held through a whole run does not disturb the sequence
      Go = 1'b1;
      do_prog(0, 3, 0);
      do_prog(1, 4, 0);
      do_prog(2, 5, 0);
      Go = 1'b0;
      finish_run(5);

      // Go and Abort together in IDLE: Abort wins
      Go    = 1'b1;
      Abort = 1'b1;
      @(negedge Clk);
      Go    = 1'b0;
      Abort = 1'b0;
      chk("t6_goabort_busy", Busy, 0);
      chk("t6_goabort_start", DutStart, 0);

      // Reset dropped mid-START: DutStart falls with no clock edge
      @(negedge Clk);
      pulse_go();
      chk("t6_pre_rst_start", DutStart, 1);
      #2 Reset_n = 1'b0;
      #1;
      chk("t6_async_start", DutStart, 0);
      chk("t6_async_busy", Busy, 0);
      @(negedge Clk);
      Reset_n = 1'b1;
      @(negedge Clk);
      chk("t6_post_rst_busy", Busy, 0);
      chk("t6_post_rst_rv", ResultValid, 0);
      chk("t6_post_rst_count", CycleCount, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
